// File: rtl/sweep_controller_pkg.sv
// Shared definitions for the divisor sweep controller: state encoding,
// default widths and the minimum dwell count.
package sweep_controller_pkg;

   localparam int DIV_W_DEFAULT   = 16;
   localparam int DWELL_W_DEFAULT = 8;

   // A dwell of zero is treated as this many div_tick pulses.
   localparam int MIN_DWELL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DWELL,
      ST_STEP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sweep_step_calc.sv
// Next-divisor arithmetic for the sweep: adds or subtracts the step in one
// extra bit so that carry/borrow is visible, then flags any result that
// overflowed or went beyond the sweep limit.
module sweep_step_calc #(
   parameter int W = 16
) (
   input  logic [W-1:0] current,
   input  logic [W-1:0] step,
   input  logic [W-1:0] limit,
   input  logic         down,
   output logic [W-1:0] next,
   output logic         past_limit
);

   logic [W:0] sum;

   // Widened add/subtract and limit comparison; a carry or borrow always counts as past the limit
   always_comb begin
      if (down) begin
         sum = {1'b0, current} - {1'b0, step};
      end else begin
         sum = {1'b0, current} + {1'b0, step};
      end
      next = sum[W-1:0];
      if (sum[W]) begin
         past_limit = 1'b1;
      end else if (down) begin
         past_limit = (sum[W-1:0] < limit);
      end else begin
         past_limit = (sum[W-1:0] > limit);
      end
   end

endmodule

// File: rtl/sweep_controller.sv
// Divisor sweep controller: steps a clock-divider divisor from a first value
// towards a limit, holding each value for a number of div_tick pulses, with
// optional looping and an abort that returns to idle immediately.
module sweep_controller
   import sweep_controller_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEFAULT,
   parameter int DWELL_W = DWELL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [DIV_W-1:0]   cfg_first,
   input  logic [DIV_W-1:0]   cfg_last,
   input  logic [DIV_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_down,
   input  logic               cfg_loop,
   input  logic               div_tick,
   output logic [DIV_W-1:0]   divisor,
   output logic               divisor_load,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   localparam logic [DWELL_W-1:0] MIN_DWELL_W = DWELL_W'(MIN_DWELL);
   localparam logic [DWELL_W-1:0] ONE_DWELL   = DWELL_W'(1);

   state_t               state_reg, state_next;
   logic [DIV_W-1:0]     first_reg, first_next;
   logic [DIV_W-1:0]     last_reg, last_next;
   logic [DIV_W-1:0]     step_reg, step_next;
   logic [DWELL_W-1:0]   dwell_reg, dwell_next;
   logic                 down_reg, down_next;
   logic                 loop_reg, loop_next;
   logic [DIV_W-1:0]     cur_reg, cur_next;
   logic [DWELL_W-1:0]   cnt_reg, cnt_next;
   logic [DIV_W-1:0]     divisor_reg, divisor_next;
   logic                 load_reg, load_next;
   logic                 err_reg, err_next;

   logic                 cfg_valid;
   logic [DWELL_W-1:0]   dwell_target;
   logic [DWELL_W-1:0]   cnt_inc;
   logic [DIV_W-1:0]     calc_next;
   logic                 calc_past;

   sweep_step_calc #(
      .W (DIV_W)
   ) u_step_calc (
      .current    (cur_reg),
      .step       (step_reg),
      .limit      (last_reg),
      .down       (down_reg),
      .next       (calc_next),
      .past_limit (calc_past)
   );

   // Start-time configuration check and dwell helpers
   always_comb begin
      cfg_valid    = (cfg_step != '0) &&
                     (cfg_down ? (cfg_first >= cfg_last) : (cfg_first <= cfg_last));
      dwell_target = (dwell_reg < MIN_DWELL_W) ? MIN_DWELL_W : dwell_reg;
      cnt_inc      = cnt_reg + ONE_DWELL;
   end

   // Next-state and datapath update; abort overrides everything outside IDLE
   always_comb begin
      state_next   = state_reg;
      first_next   = first_reg;
      last_next    = last_reg;
      step_next    = step_reg;
      dwell_next   = dwell_reg;
      down_next    = down_reg;
      loop_next    = loop_reg;
      cur_next     = cur_reg;
      cnt_next     = cnt_reg;
      divisor_next = divisor_reg;
      load_next    = 1'b0;
      err_next     = 1'b0;

      if (abort && (state_reg != ST_IDLE)) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_valid) begin
                     first_next = cfg_first;
                     last_next  = cfg_last;
                     step_next  = cfg_step;
                     dwell_next = cfg_dwell;
                     down_next  = cfg_down;
                     loop_next  = cfg_loop;
                     cur_next   = cfg_first;
                     state_next = ST_LOAD;
                  end else begin
                     err_next = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               divisor_next = cur_reg;
               load_next    = 1'b1;
               cnt_next     = '0;
               state_next   = ST_DWELL;
            end
            ST_DWELL: begin
               if (div_tick) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == dwell_target) begin
                     state_next = ST_STEP;
                  end
               end
            end
            ST_STEP: begin
               if (!calc_past) begin
                  cur_next   = calc_next;
                  state_next = ST_LOAD;
               end else if (loop_reg) begin
                  cur_next   = first_reg;
                  state_next = ST_LOAD;
               end else begin
                  state_next = ST_DONE;
               end
            end
            ST_DONE: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Latched configuration, sweep position, dwell counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_reg   <= '0;
         last_reg    <= '0;
         step_reg    <= '0;
         dwell_reg   <= '0;
         down_reg    <= 1'b0;
         loop_reg    <= 1'b0;
         cur_reg     <= '0;
         cnt_reg     <= '0;
         divisor_reg <= '0;
         load_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         first_reg   <= first_next;
         last_reg    <= last_next;
         step_reg    <= step_next;
         dwell_reg   <= dwell_next;
         down_reg    <= down_next;
         loop_reg    <= loop_next;
         cur_reg     <= cur_next;
         cnt_reg     <= cnt_next;
         divisor_reg <= divisor_next;
         load_reg    <= load_next;
         err_reg     <= err_next;
      end
   end

   // Output drive; done is suppressed if abort arrives in the completion cycle
   always_comb begin
      divisor      = divisor_reg;
      divisor_load = load_reg;
      cfg_err      = err_reg;
      busy         = (state_reg != ST_IDLE);
      done         = (state_reg == ST_DONE) && !abort;
   end

endmodule

// File: tb/tb_sweep_controller.sv
// Directed testbench for sweep_controller: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_sweep_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] cfg_first;
   logic [15:0] cfg_last;
   logic [15:0] cfg_step;
   logic [7:0]  cfg_dwell;
   logic        cfg_down;
   logic        cfg_loop;
   logic        div_tick;
   logic [15:0] divisor;
   logic        divisor_load;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int test_cnt = 0;
   int fail_cnt = 0;

   logic [15:0] load_q[$];
   int          tick_q[$];
   int          ticks_since = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          viol_cnt = 0;
   logic [15:0] prev_div = '0;

   sweep_controller #(
      .DIV_W   (16),
      .DWELL_W (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_first    (cfg_first),
      .cfg_last     (cfg_last),
      .cfg_step     (cfg_step),
      .cfg_dwell    (cfg_dwell),
      .cfg_down     (cfg_down),
      .cfg_loop     (cfg_loop),
      .div_tick     (div_tick),
      .divisor      (divisor),
      .divisor_load (divisor_load),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   // Observe outputs on the falling edge: record loads, ticks, pulses and illegal divisor changes
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         prev_div = divisor;
      end else begin
         if ((divisor !== prev_div) && (divisor_load !== 1'b1)) viol_cnt++;
         prev_div = divisor;
         if (divisor_load === 1'b1) begin
            load_q.push_back(divisor);
            tick_q.push_back(ticks_since);
            ticks_since = 0;
            $display("[TB] t=%0t load divisor=%h", $time, divisor);
         end
         if (div_tick === 1'b1) ticks_since++;
         if (done === 1'b1) begin
            done_cnt++;
            $display("[TB] t=%0t done pulse", $time);
         end
         if (cfg_err === 1'b1) begin
            err_cnt++;
            $display("[TB] t=%0t cfg_err pulse", $time);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      load_q.delete();
      tick_q.delete();
      ticks_since = 0;
      done_cnt = 0;
      err_cnt = 0;
      viol_cnt = 0;
   endtask

   // Present a configuration with start for one sampling edge; returns just after that edge
   task automatic do_start(input logic [15:0] f, input logic [15:0] l, input logic [15:0] s,
                           input logic [7:0] d, input logic dn, input logic lp);
      cfg_first = f;
      cfg_last  = l;
      cfg_step  = s;
      cfg_dwell = d;
      cfg_down  = dn;
      cfg_loop  = lp;
      start     = 1'b1;
      cyc(1);
      start     = 1'b0;
   endtask

   task automatic pulse_tick();
      div_tick = 1'b1;
      cyc(1);
      div_tick = 1'b0;
      cyc(3);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      div_tick = 1'b0;
      cfg_first = '0;
      cfg_last = '0;
      cfg_step = '0;
      cfg_dwell = '0;
      cfg_down = 1'b0;
      cfg_loop = 1'b0;
      cyc(3);
      test_cnt++; if (divisor !== 16'h0000) begin fail_cnt++; $display("FAIL reset_divisor got %h need 0000", divisor); end
      test_cnt++; if (divisor_load !== 1'b0) begin fail_cnt++; $display("FAIL reset_load got %b need 0", divisor_load); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b need 0", busy); end
      test_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done got %b need 0", done); end
      test_cnt++; if (cfg_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_cfg_err got %b need 0", cfg_err); end
      rst = 1'b0;
      cyc(2);
      clear_mon();
   endtask

   task automatic test_up_sweep();
      logic [15:0] exp_div[4] = '{16'd100, 16'd110, 16'd120, 16'd130};
      int          exp_tk[4]  = '{0, 2, 2, 2};
      $display("[TB] scenario: ascending sweep 100..130 step 10 dwell 2");
      clear_mon();
      do_start(16'd100, 16'd130, 16'd10, 8'd2, 1'b0, 1'b0);
      test_cnt++; if (divisor_load !== 1'b0) begin fail_cnt++; $display("FAIL up_load_early got %b need 0", divisor_load); end
      test_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL up_busy got %b need 1", busy); end
      cyc(1);
      test_cnt++; if (divisor_load !== 1'b1) begin fail_cnt++; $display("FAIL up_first_load got %b need 1", divisor_load); end
      test_cnt++; if (divisor !== 16'd100) begin fail_cnt++; $display("FAIL up_first_divisor got %0d need 100", divisor); end
      cyc(1);
      test_cnt++; if (divisor_load !== 1'b0) begin fail_cnt++; $display("FAIL up_load_width got %b need 0", divisor_load); end
      for (int i = 0; i < 40 && busy === 1'b1; i++) pulse_tick();
      cyc(2);
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL up_end_busy got %b need 0", busy); end
      test_cnt++; if (load_q.size() !== 4) begin fail_cnt++; $display("FAIL up_load_count got %0d need 4", load_q.size()); end
      for (int i = 0; i < 4; i++) begin
         test_cnt++;
         if (i >= load_q.size()) begin
            fail_cnt++; $display("FAIL up_load_value[%0d] got none need %0d", i, exp_div[i]);
         end else if (load_q[i] !== exp_div[i] || tick_q[i] !== exp_tk[i]) begin
            fail_cnt++; $display("FAIL up_load_value[%0d] got %0d after %0d ticks need %0d after %0d ticks",
                                 i, load_q[i], tick_q[i], exp_div[i], exp_tk[i]);
         end
      end
      test_cnt++; if (done_cnt !== 1) begin fail_cnt++; $display("FAIL up_done_count got %0d need 1", done_cnt); end
      test_cnt++; if (err_cnt !== 0) begin fail_cnt++; $display("FAIL up_cfg_err_count got %0d need 0", err_cnt); end
      test_cnt++; if (viol_cnt !== 0) begin fail_cnt++; $display("FAIL up_divisor_stable got %0d changes need 0", viol_cnt); end
   endtask

   task automatic test_down_loop();
      logic [15:0] exp_div[6] = '{16'd50, 16'd30, 16'd50, 16'd30, 16'd50, 16'd30};
      $display("[TB] scenario: descending looping sweep 50..20 step 20");
      clear_mon();
      do_start(16'd50, 16'd20, 16'd20, 8'd1, 1'b1, 1'b1);
      cyc(1);
      repeat (5) pulse_tick();
      test_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL loop_still_busy got %b need 1", busy); end
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      cyc(2);
      test_cnt++; if (load_q.size() !== 6) begin fail_cnt++; $display("FAIL loop_load_count got %0d need 6", load_q.size()); end
      for (int i = 0; i < 6; i++) begin
         test_cnt++;
         if (i >= load_q.size()) begin
            fail_cnt++; $display("FAIL loop_load_value[%0d] got none need %0d", i, exp_div[i]);
         end else if (load_q[i] !== exp_div[i]) begin
            fail_cnt++; $display("FAIL loop_load_value[%0d] got %0d need %0d", i, load_q[i], exp_div[i]);
         end
      end
      test_cnt++; if (done_cnt !== 0) begin fail_cnt++; $display("FAIL loop_done_count got %0d need 0", done_cnt); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL loop_abort_busy got %b need 0", busy); end
      test_cnt++; if (divisor !== 16'd30) begin fail_cnt++; $display("FAIL loop_divisor_held got %0d need 30", divisor); end
   endtask

   task automatic test_dwell_zero();
      $display("[TB] scenario: dwell 0 treated as 1, sweep 1..2");
      clear_mon();
      do_start(16'd1, 16'd2, 16'd1, 8'd0, 1'b0, 1'b0);
      cyc(1);
      for (int i = 0; i < 10 && busy === 1'b1; i++) pulse_tick();
      cyc(2);
      test_cnt++; if (load_q.size() !== 2) begin fail_cnt++; $display("FAIL dwell0_load_count got %0d need 2", load_q.size()); end
      test_cnt++;
      if (load_q.size() < 2) begin
         fail_cnt++; $display("FAIL dwell0_second_load got none need 2 after 1 tick");
      end else if (load_q[1] !== 16'd2 || tick_q[1] !== 1) begin
         fail_cnt++; $display("FAIL dwell0_second_load got %0d after %0d ticks need 2 after 1 tick", load_q[1], tick_q[1]);
      end
      test_cnt++; if (done_cnt !== 1) begin fail_cnt++; $display("FAIL dwell0_done_count got %0d need 1", done_cnt); end
   endtask

   task automatic test_cfg_err();
      $display("[TB] scenario: rejected configurations");
      clear_mon();
      do_start(16'd10, 16'd20, 16'd0, 8'd1, 1'b0, 1'b0);
      test_cnt++; if (cfg_err !== 1'b1) begin fail_cnt++; $display("FAIL err_step0_pulse got %b need 1", cfg_err); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL err_step0_busy got %b need 0", busy); end
      cyc(1);
      test_cnt++; if (cfg_err !== 1'b0) begin fail_cnt++; $display("FAIL err_step0_width got %b need 0", cfg_err); end
      do_start(16'd10, 16'd5, 16'd1, 8'd1, 1'b0, 1'b0);
      test_cnt++; if (cfg_err !== 1'b1) begin fail_cnt++; $display("FAIL err_up_order_pulse got %b need 1", cfg_err); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL err_up_order_busy got %b need 0", busy); end
      cyc(1);
      do_start(16'd5, 16'd10, 16'd1, 8'd1, 1'b1, 1'b0);
      test_cnt++; if (cfg_err !== 1'b1) begin fail_cnt++; $display("FAIL err_down_order_pulse got %b need 1", cfg_err); end
      cyc(3);
      test_cnt++; if (err_cnt !== 3) begin fail_cnt++; $display("FAIL err_pulse_count got %0d need 3", err_cnt); end
      test_cnt++; if (load_q.size() !== 0) begin fail_cnt++; $display("FAIL err_no_load got %0d loads need 0", load_q.size()); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL err_end_busy got %b need 0", busy); end
   endtask

   task automatic test_carry();
      $display("[TB] scenario: carry out of FFF0 + 0020");
      clear_mon();
      do_start(16'hFFF0, 16'hFFFF, 16'h0020, 8'd1, 1'b0, 1'b0);
      cyc(1);
      for (int i = 0; i < 10 && busy === 1'b1; i++) pulse_tick();
      cyc(2);
      test_cnt++; if (load_q.size() !== 1) begin fail_cnt++; $display("FAIL carry_load_count got %0d need 1", load_q.size()); end
      test_cnt++; if (divisor !== 16'hFFF0) begin fail_cnt++; $display("FAIL carry_divisor got %h need fff0", divisor); end
      test_cnt++; if (done_cnt !== 1) begin fail_cnt++; $display("FAIL carry_done_count got %0d need 1", done_cnt); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL carry_busy got %b need 0", busy); end
   endtask

   task automatic test_abort();
      $display("[TB] scenario: abort coincident with div_tick, start ignored while busy");
      clear_mon();
      do_start(16'd5, 16'd100, 16'd5, 8'd3, 1'b0, 1'b0);
      cyc(1);
      start = 1'b1;
      cfg_first = 16'd77;
      pulse_tick();
      pulse_tick();
      start = 1'b0;
      div_tick = 1'b1;
      abort = 1'b1;
      cyc(1);
      div_tick = 1'b0;
      abort = 1'b0;
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL abort_busy got %b need 0", busy); end
      test_cnt++; if (divisor !== 16'd5) begin fail_cnt++; $display("FAIL abort_divisor_held got %0d need 5", divisor); end
      test_cnt++; if (divisor_load !== 1'b0) begin fail_cnt++; $display("FAIL abort_no_load got %b need 0", divisor_load); end
      cyc(4);
      test_cnt++; if (load_q.size() !== 1) begin fail_cnt++; $display("FAIL abort_load_count got %0d need 1", load_q.size()); end
      test_cnt++; if (done_cnt !== 0) begin fail_cnt++; $display("FAIL abort_done_count got %0d need 0", done_cnt); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL abort_stays_idle got %b need 0", busy); end
   endtask

   task automatic test_reset_mid();
      $display("[TB] scenario: reset asserted between edges during dwell");
      clear_mon();
      do_start(16'd40, 16'd200, 16'd10, 8'd4, 1'b0, 1'b0);
      cyc(1);
      pulse_tick();
      #2;
      rst = 1'b1;
      #1;
      test_cnt++; if (divisor !== 16'h0000) begin fail_cnt++; $display("FAIL rstmid_divisor got %h need 0000", divisor); end
      test_cnt++; if (divisor_load !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_load got %b need 0", divisor_load); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_busy got %b need 0", busy); end
      test_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_done got %b need 0", done); end
      test_cnt++; if (cfg_err !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_cfg_err got %b need 0", cfg_err); end
      cyc(1);
      rst = 1'b0;
      cyc(1);
      clear_mon();
      repeat (3) pulse_tick();
      test_cnt++; if (load_q.size() !== 0) begin fail_cnt++; $display("FAIL rstmid_quiet_loads got %0d need 0", load_q.size()); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_quiet_busy got %b need 0", busy); end
      do_start(16'd40, 16'd200, 16'd10, 8'd4, 1'b0, 1'b0);
      cyc(1);
      test_cnt++; if (divisor_load !== 1'b1 || divisor !== 16'd40) begin
         fail_cnt++; $display("FAIL rstmid_restart got load=%b divisor=%0d need load=1 divisor=40", divisor_load, divisor);
      end
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      cyc(1);
   endtask

   initial begin
      test_reset();
      test_up_sweep();
      test_down_loop();
      test_dwell_zero();
      test_cfg_err();
      test_carry();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
